// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch
// PC and runs a single-outstanding request/response handshake with
// instruction memory. A fetched word is held in ibuf_q and presented on
// InstrF while the stage is READY; in every other state a NOP is presented
// and bubble_o tells IF/ID to flush.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   stallF         in   hazard unit: hold the current instruction and PC
//   redirect_i     in   taken branch/jump from EX (one-cycle pulse)
//   redirect_pc_i  in   redirect target (low two bits ignored)
//   imem_req_o     out  memory request strobe, accepted in the cycle asserted
//   imem_addr_o    out  word-aligned request address
//   imem_rvalid_i  in   response valid (in order, >= 1 cycle after request)
//   imem_rdata_i   in   response instruction word
//   InstrF         out  fetched instruction to IF/ID
//   PCF            out  PC of InstrF
//   PCPlus4F       out  PCF + 4 (32-bit wrap)
//   bubble_o       out  1 = no valid instruction this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        bubble_o
);

    typedef enum logic [1:0] {
        REQ   = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ibuf_q;
    // Set when the PC was redirected while a request was in flight: the
    // response that eventually returns belongs to the old path and is dropped.
    logic        drop_q;

    logic [31:0] target_s;

    // Redirect target, forced onto a word boundary.
    assign target_s = redirect_pc_i & 32'hFFFF_FFFC;

    // Fetch state machine: PC, instruction buffer and drop tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            ibuf_q  <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    // A redirect in REQ suppresses the request, so nothing
                    // is outstanding and no drop is needed.
                    if (redirect_i) begin
                        pc_q <= target_s;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q || redirect_i) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                            if (redirect_i) begin
                                pc_q <= target_s;
                            end else begin
                                pc_q <= pc_q;
                            end
                        end else begin
                            ibuf_q  <= imem_rdata_i;
                            state_q <= READY;
                        end
                    end else if (redirect_i) begin
                        pc_q   <= target_s;
                        drop_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                READY: begin
                    // Redirect wins over a stall: the held instruction is on
                    // the wrong path anyway.
                    if (redirect_i) begin
                        pc_q    <= target_s;
                        ibuf_q  <= NOP_INSTR;
                        state_q <= REQ;
                    end else if (!stallF) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= REQ;
                    end else begin
                        state_q <= READY;
                    end
                end
                default: begin
                    state_q <= REQ;
                    pc_q    <= RESET_PC;
                    ibuf_q  <= NOP_INSTR;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    // Request strobe: only from REQ, and never in a cycle being redirected
    // or held in reset.
    always_comb begin
        imem_req_o = 1'b0;
        if ((state_q == REQ) && !redirect_i && !reset) begin
            imem_req_o = 1'b1;
        end else begin
            imem_req_o = 1'b0;
        end
    end

    // Stage outputs decoded from the registered state.
    always_comb begin
        InstrF   = NOP_INSTR;
        bubble_o = 1'b1;
        if (state_q == READY) begin
            InstrF   = ibuf_q;
            bubble_o = 1'b0;
        end else begin
            InstrF   = NOP_INSTR;
            bubble_o = 1'b1;
        end
    end

    assign imem_addr_o = pc_q & 32'hFFFF_FFFC;
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_q + 32'd4;

endmodule
